// File: rtl/pmod_ad1_pkg.sv
// Shared types and frame constants for the PmodAD1 serial controller.
package pmod_ad1_pkg;

  typedef enum logic [1:0] {
    QUIET = 2'd0,
    IDLE  = 2'd1,
    CONV  = 2'd2
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_BITS  = 12;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

endpackage

// File: rtl/pmod_ad1_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle high/low phases, a sample strobe in the cycle
// whose edge drives SCLK low, and a strobe at the end of the last low phase.
module pmod_ad1_sclk_gen
  import pmod_ad1_pkg::*;
#(
  parameter int CLK_DIV = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic fall_tick_o,
  output logic frame_done_o
);

  localparam logic [7:0]           HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_BITS - 1);

  logic [7:0]           half_q, half_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 sclk_q, sclk_d;
  logic                 half_last;

  assign half_last = (half_q == HALF_LAST);

  always_comb begin
    half_d = half_q;
    bit_d  = bit_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      // Disabled: park high with counters cleared so the next frame starts aligned.
      half_d = '0;
      bit_d  = '0;
      sclk_d = 1'b1;
    end else if (half_last) begin
      half_d = '0;
      sclk_d = ~sclk_q;
      if (!sclk_q) bit_d = bit_q + BIT_CNT_W'(1);
    end else begin
      half_d = half_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_q <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      half_q <= half_d;
      bit_q  <= bit_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign fall_tick_o  = en_i & sclk_q & half_last;
  assign frame_done_o = en_i & ~sclk_q & half_last & (bit_q == BIT_LAST);

endmodule

// File: rtl/pmod_ad1_ctrl.sv
// PmodAD1 initiator: runs CS/SCLK framing, deserialises both ADC lines and
// presents one 12-bit sample per channel per frame.
module pmod_ad1_ctrl
  import pmod_ad1_pkg::*;
#(
  parameter int CLK_DIV      = 3,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data0,
  output logic [DATA_BITS-1:0] data1,
  output logic                 valid,
  output logic                 err,
  output logic                 ad1_cs,
  output logic                 ad1_sclk,
  input  logic                 ad1_sdin0,
  input  logic                 ad1_sdin1,
  output state_e               dbg_state
);

  // Handshake: start is taken only in a cycle with ready=1 (no queuing);
  // valid is a one-cycle pulse, data0/data1/err hold until the next pulse.

  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [7:0]             quiet_q, quiet_d;
  logic [FRAME_BITS-1:0]  sh0_q, sh0_d, sh1_q, sh1_d;
  logic [DATA_BITS-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                   cs_q, cs_d, ready_q, ready_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic                   fall_tick, frame_done;

  pmod_ad1_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (state_q == CONV),
    .sclk_o       (ad1_sclk),
    .fall_tick_o  (fall_tick),
    .frame_done_o (frame_done)
  );

  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    err_d   = err_q;
    cs_d    = 1'b1;
    ready_d = 1'b0;
    valid_d = 1'b0;
    unique case (state_q)
      QUIET: begin
        if (quiet_q == QUIET_LAST) begin
          state_d = IDLE;
          quiet_d = '0;
          ready_d = 1'b1;
        end else begin
          quiet_d = quiet_q + 8'd1;
        end
      end
      IDLE: begin
        if (start) begin
          state_d = CONV;
          cs_d    = 1'b0;
          sh0_d   = '0;
          sh1_d   = '0;
        end else begin
          ready_d = 1'b1;
        end
      end
      CONV: begin
        cs_d = 1'b0;
        if (fall_tick) begin
          sh0_d = {sh0_q[FRAME_BITS-2:0], ad1_sdin0};
          sh1_d = {sh1_q[FRAME_BITS-2:0], ad1_sdin1};
        end
        // The 16th sample was taken on an earlier edge, so the shifters are complete here.
        if (frame_done) begin
          state_d = QUIET;
          cs_d    = 1'b1;
          valid_d = 1'b1;
          data0_d = sh0_q[DATA_BITS-1:0];
          data1_d = sh1_q[DATA_BITS-1:0];
          err_d   = (sh0_q[FRAME_BITS-1 -: LEAD_ZEROS] != '0) |
                    (sh1_q[FRAME_BITS-1 -: LEAD_ZEROS] != '0);
        end
      end
      default: state_d = QUIET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= QUIET;
      quiet_q <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready     = ready_q;
  assign data0     = data0_q;
  assign data1     = data1_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign ad1_cs    = cs_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pmod_ad1_ctrl.sv
// Bench for pmod_ad1_ctrl: behavioural AD7476A models on the serial pins and a
// frame-level reference model feeding an expected-result queue.
module tb_pmod_ad1_ctrl;
  import pmod_ad1_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;

  logic        a_ready, a_valid, a_err, a_cs, a_sclk, a_sd0 = 1'b0, a_sd1 = 1'b0;
  logic [11:0] a_d0, a_d1;
  state_e      a_state;
  logic        b_ready, b_valid, b_err, b_cs, b_sclk, b_sd0 = 1'b0, b_sd1 = 1'b0;
  logic [11:0] b_d0, b_d1;
  state_e      b_state;

  pmod_ad1_ctrl #(.CLK_DIV(2), .QUIET_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ready(a_ready),
    .data0(a_d0), .data1(a_d1), .valid(a_valid), .err(a_err),
    .ad1_cs(a_cs), .ad1_sclk(a_sclk), .ad1_sdin0(a_sd0), .ad1_sdin1(a_sd1),
    .dbg_state(a_state)
  );

  pmod_ad1_ctrl #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ready(b_ready),
    .data0(b_d0), .data1(b_d1), .valid(b_valid), .err(b_err),
    .ad1_cs(b_cs), .ad1_sclk(b_sclk), .ad1_sdin0(b_sd0), .ad1_sdin1(b_sd1),
    .dbg_state(b_state)
  );

  // ---------------- ADC models: bit 0 at CS fall, bit n after SCLK fall n ----------------
  logic [15:0] adc_a0 = '0, adc_a1 = '0, adc_b0 = '0, adc_b1 = '0;
  int idx_a = 0, idx_b = 0;

  function automatic logic bit_of(input logic [15:0] w, input int i);
    logic [3:0] pos;
    pos = 4'(15 - i);
    return (i < 16) ? w[pos] : 1'b0;
  endfunction

  always @(negedge a_cs) begin
    idx_a = 0; a_sd0 = bit_of(adc_a0, 0); a_sd1 = bit_of(adc_a1, 0);
  end
  always @(negedge a_sclk) if (a_cs === 1'b0) begin
    idx_a++; a_sd0 = bit_of(adc_a0, idx_a); a_sd1 = bit_of(adc_a1, idx_a);
  end
  always @(negedge b_cs) begin
    idx_b = 0; b_sd0 = bit_of(adc_b0, 0); b_sd1 = bit_of(adc_b1, 0);
  end
  always @(negedge b_sclk) if (b_cs === 1'b0) begin
    idx_b++; b_sd0 = bit_of(adc_b0, idx_b); b_sd1 = bit_of(adc_b1, idx_b);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame result {err, data1, data0} from the two 16-bit words the ADCs send.
  function automatic logic [24:0] ref_frame(input logic [15:0] w0, input logic [15:0] w1);
    return {(w0[15:12] != 4'h0) || (w1[15:12] != 4'h0), w1[11:0], w0[11:0]};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [3:0] lead;
    lead = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    return {lead, 12'($urandom_range(0, 4095))};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready_a();
    int n;
    n = 0;
    @(negedge clk);
    while (a_ready !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("ready_timeout", 32'(a_ready), 32'd1);
  endtask

  // One frame on dut_a; n counts sampling points after the start cycle T (n=1 is T+1).
  task automatic run_frame(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                           input bit mid_pulse);
    int n, lows, falls, vat, extra_lows, extra_valids;
    logic prev_sclk;
    logic [24:0] got, exp;
    adc_a0 = w0; adc_a1 = w1;
    wait_ready_a();
    start_a = 1'b1;
    exp_q.push_back(ref_frame(w0, w1));
    n = 0; lows = 0; falls = 0; vat = -1; prev_sclk = 1'b1; got = 'x;
    while (vat < 0 && n < 120) begin
      @(negedge clk); n++;
      start_a = mid_pulse && (n == 20);
      if (a_cs === 1'b0) lows++;
      if (prev_sclk === 1'b1 && a_sclk === 1'b0) falls++;
      prev_sclk = a_sclk;
      if (a_valid === 1'b1) begin
        vat = n; got = {a_err, a_d1, a_d0};
      end
    end
    start_a = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_valid_time"}, 32'(vat), 32'd65);
    check({tag, "_cs_low"}, 32'(lows), 32'd64);
    check({tag, "_sclk_falls"}, 32'(falls), 32'd16);
    check({tag, "_data"}, 32'(got), 32'(exp));
    extra_lows = 0; extra_valids = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_cs !== 1'b1) extra_lows++;
      if (a_valid !== 1'b0) extra_valids++;
    end
    check({tag, "_no_extra_frame"}, 32'(extra_lows + extra_valids), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int early, n, fr, vals, gaps, gap_bad, run, f1, f2, vat, rdy_at;
    logic prev_cs, prev_sclk;
    logic [15:0] w0, w1;
    logic [24:0] got;

    // Reset for 3 cycles
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {a_cs, a_sclk, a_ready, a_valid, a_err, 3'b0, a_d0, a_d1},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b0, 12'h0, 12'h0});
    end
    rst = 1'b0;
    early = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (a_ready !== 1'b0) early++;
    end
    check("ready_early_after_reset", 32'(early), 32'd0);
    @(negedge clk);
    check("ready_after_reset", 32'(a_ready), 32'd1);

    // Known pattern, then error frame, then clean frame, then a start pulse during CONV
    run_frame("abc_123", 16'h0ABC, 16'h0123, 1'b0);
    run_frame("err_ch1", 16'h0555, 16'h8FFF, 1'b0);
    check("err_flag_set", 32'(a_err), 32'd1);
    run_frame("clean_after_err", 16'h0FA5, 16'h05AF, 1'b0);
    check("err_flag_clear", 32'(a_err), 32'd0);
    run_frame("pulse_in_conv", 16'h0321, 16'h0C0C, 1'b1);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      w0 = rand_word(); w1 = rand_word();
      run_frame("random", w0, w1, 1'b0);
    end

    // start held high across three frames
    w0 = rand_word(); w1 = rand_word();
    adc_a0 = w0; adc_a1 = w1;
    wait_ready_a();
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_frame(w0, w1));
    start_a = 1'b1;
    n = 0; fr = 0; vals = 0; gaps = 0; gap_bad = 0; run = -1; prev_cs = 1'b1;
    while (n < 400 && !(vals == 3 && run > 20)) begin
      @(negedge clk); n++;
      if (prev_cs === 1'b1 && a_cs === 1'b0) begin
        fr++;
        if (run >= 0) begin
          gaps++;
          if (run != 9) gap_bad++;
        end
        run = -1;
      end
      if (prev_cs === 1'b0 && a_cs === 1'b1) run = 0;
      if (a_cs === 1'b1 && run >= 0) run++;
      prev_cs = a_cs;
      if (fr == 3 && a_cs === 1'b0 && run < 0 && n > 170) start_a = 1'b0;
      if (a_valid === 1'b1) begin
        vals++;
        got = {a_err, a_d1, a_d0};
        check("b2b_data", 32'(got), 32'(exp_q.size() > 0 ? exp_q.pop_front() : 25'h0));
      end
    end
    start_a = 1'b0;
    check("b2b_frames", 32'(fr), 32'd3);
    check("b2b_valids", 32'(vals), 32'd3);
    check("b2b_gaps", 32'(gaps), 32'd2);
    check("b2b_gap_len", 32'(gap_bad), 32'd0);

    // Reset at the 7th SCLK fall
    adc_a0 = 16'h0ABC; adc_a1 = 16'h0DEF;
    wait_ready_a();
    start_a = 1'b1;
    n = 0; fr = 0; vals = 0; prev_sclk = 1'b1;
    while (fr < 7 && n < 120) begin
      @(negedge clk); n++;
      start_a = 1'b0;
      if (prev_sclk === 1'b1 && a_sclk === 1'b0) fr++;
      prev_sclk = a_sclk;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_sclk", {30'h0, a_cs, a_sclk}, 32'h3);
    if (a_valid !== 1'b0) vals++;
    @(negedge clk);
    if (a_valid !== 1'b0) vals++;
    rst = 1'b0;
    early = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (a_ready !== 1'b0) early++;
      if (a_valid !== 1'b0) vals++;
    end
    @(negedge clk);
    check("midrst_no_valid", 32'(vals), 32'd0);
    check("midrst_data", {8'h0, a_d0, a_d1}, 32'h0);
    check("midrst_ready_early", 32'(early), 32'd0);
    check("midrst_ready", 32'(a_ready), 32'd1);

    // CLK_DIV=1, QUIET_CYCLES=1 instance
    adc_b0 = 16'h0FFF; adc_b1 = 16'h0000;
    n = 0;
    while (b_ready !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    start_b = 1'b1;
    n = 0; fr = 0; f1 = -1; f2 = -1; vat = -1; rdy_at = -1; prev_sclk = 1'b1; got = 'x;
    while (rdy_at < 0 && n < 80) begin
      @(negedge clk); n++;
      start_b = 1'b0;
      if (prev_sclk === 1'b1 && b_sclk === 1'b0) begin
        fr++;
        if (fr == 1) f1 = n;
        if (fr == 2) f2 = n;
      end
      prev_sclk = b_sclk;
      if (b_valid === 1'b1) begin
        vat = n; got = {b_err, b_d1, b_d0};
      end
      if (vat > 0 && b_ready === 1'b1) rdy_at = n;
    end
    check("div1_sclk_period", 32'(f2 - f1), 32'd2);
    check("div1_falls", 32'(fr), 32'd16);
    check("div1_valid_time", 32'(vat), 32'd33);
    check("div1_data", 32'(got), 32'(ref_frame(16'h0FFF, 16'h0000)));
    check("div1_ready_time", 32'(rdy_at), 32'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
